calendar_uart_tx: RTL and testbench

- Transmit side of the calendar's serial link; the receive side loads Day/Month/Year from UART.
- On a send request, snapshots the current Day/Month/Year from the calendar block.
- Formats the snapshot as ASCII text "YY-MM-DD\r\n" and shifts it out as 8N1 UART frames on a single tx line.
- Sits between the calendar counters and the board's UART TX pin.

---
 rtl/calendar_uart_tx_if.sv | 14 +
 rtl/calendar_uart_tx.sv | 133 +++++++++++++
 tb/tb_calendar_uart_tx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/calendar_uart_tx_if.sv
// Signal bundle between the calendar block / UART pin and calendar_uart_tx.
// master drives the calendar fields and send request; slave is the transmitter.
interface calendar_uart_tx_if;
   logic [6:0] Day;
   logic [6:0] Month;
   logic [6:0] Year;
   logic       send;
   logic       tx;
   logic       busy;
   logic       done;

   modport master (output Day, Month, Year, send, input tx, busy, done);
   modport slave  (input Day, Month, Year, send, output tx, busy, done);
endinterface

// File: rtl/calendar_uart_tx.sv
// Snapshots Day/Month/Year on a send edge and transmits "YY-MM-DD\r\n" as 8N1 frames.
// Define CAL_TX_CENTURY_EN to prefix the report with "20" (12 bytes).
module calendar_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 5208
) (
   input logic               clk,
   input logic               reset,
   calendar_uart_tx_if.slave bus
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

`ifdef CAL_TX_CENTURY_EN
   localparam int unsigned NBYTES = 12;
`else
   localparam int unsigned NBYTES = 10;
`endif
   localparam logic [3:0]  LAST_BYTE = 4'(NBYTES - 1);
   localparam logic [15:0] BAUD_MAX  = 16'(CLKS_PER_BIT - 1);

   state_t      state, state_nxt;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx, bit_nxt;
   logic [3:0]  byte_idx, body_idx;
   logic [6:0]  snap_d, snap_m, snap_y;
   logic        send_q, start_req, baud_done;
   logic        tx_r, busy_r, done_r, tx_nxt, done_nxt;
   logic [7:0]  cur_byte;

   function automatic logic [6:0] clamp99(input logic [6:0] n);
      return (n > 7'd99) ? 7'd99 : n;
   endfunction

   function automatic logic [7:0] tens_ascii(input logic [6:0] n);
      return {4'h3, 4'(n / 7'd10)};
   endfunction

   function automatic logic [7:0] ones_ascii(input logic [6:0] n);
      return {4'h3, 4'(n % 7'd10)};
   endfunction

   assign start_req = bus.send & ~send_q;
   assign baud_done = (baud_cnt == BAUD_MAX);
   assign bus.tx    = tx_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;

   always_comb begin
`ifdef CAL_TX_CENTURY_EN
      body_idx = byte_idx - 4'd2;
`else
      body_idx = byte_idx;
`endif
      case (body_idx)
         4'd0:    cur_byte = tens_ascii(snap_y);
         4'd1:    cur_byte = ones_ascii(snap_y);
         4'd2:    cur_byte = 8'h2D;
         4'd3:    cur_byte = tens_ascii(snap_m);
         4'd4:    cur_byte = ones_ascii(snap_m);
         4'd5:    cur_byte = 8'h2D;
         4'd6:    cur_byte = tens_ascii(snap_d);
         4'd7:    cur_byte = ones_ascii(snap_d);
         4'd8:    cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
`ifdef CAL_TX_CENTURY_EN
      if (byte_idx == 4'd0)      cur_byte = 8'h32;
      else if (byte_idx == 4'd1) cur_byte = 8'h30;
`endif
   end

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE:  if (start_req) state_nxt = START;
         START: if (baud_done) state_nxt = DATA;
         DATA:  if (baud_done && bit_idx == 3'd7) state_nxt = STOP;
         STOP: begin
            if (baud_done) begin
               if (byte_idx == LAST_BYTE) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = START;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      bit_nxt = (state == DATA && baud_done) ? bit_idx + 3'd1 : bit_idx;
      // tx is registered, so it is derived from the state being entered
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = cur_byte[bit_nxt];
         default: tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         send_q   <= 1'b1;
         tx_r     <= 1'b1;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         snap_d   <= '0;
         snap_m   <= '0;
         snap_y   <= '0;
      end else begin
         send_q   <= bus.send;
         state    <= state_nxt;
         tx_r     <= tx_nxt;
         done_r   <= done_nxt;
         busy_r   <= (state_nxt != IDLE);
         baud_cnt <= (state == IDLE || baud_done) ? '0 : baud_cnt + 16'd1;
         bit_idx  <= (state_nxt == DATA) ? bit_nxt : '0;
         if (state == IDLE && start_req) begin
            snap_d   <= clamp99(bus.Day);
            snap_m   <= clamp99(bus.Month);
            snap_y   <= clamp99(bus.Year);
            byte_idx <= '0;
         end else if (state == STOP && baud_done) begin
            byte_idx <= (byte_idx == LAST_BYTE) ? '0 : byte_idx + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_calendar_uart_tx.sv
// Self-checking bench for calendar_uart_tx: decodes the tx line and compares with a text model.
module tb_calendar_uart_tx;

   localparam int N = 4;
`ifdef CAL_TX_CENTURY_EN
   localparam int NB = 12;
`else
   localparam int NB = 10;
`endif
   localparam int REPORT_CYCLES = NB * 10 * N;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   compared = 0;
   int   mismatched = 0;

   calendar_uart_tx_if bus ();

   calendar_uart_tx #(.CLKS_PER_BIT(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected report text, built straight from the calendar values.
   task automatic ref_bytes(input int d, input int m, input int y, output logic [7:0] q[$]);
      string s;
      q = {};
      if (d > 99) d = 99;
      if (m > 99) m = 99;
      if (y > 99) y = 99;
      s = $sformatf("%02d-%02d-%02d", y, m, d);
`ifdef CAL_TX_CENTURY_EN
      s = {"20", s};
`endif
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      q.push_back(8'h0D);
      q.push_back(8'h0A);
   endtask

   // Raise send at the current negedge, record the line until done, then decode.
   task automatic run_report(input string tag, input int d, input int m, input int y,
                             input int change_at, input int glitch_at);
      logic [7:0] exp_q[$];
      logic       tx_s[$];
      int         busy_n = 0, done_n = 0, done_idx = -1;
      logic [7:0] b;
      logic       fr_start, fr_stop;
      int         idx;

      ref_bytes(d, m, y, exp_q);
      bus.Day   = 7'(d);
      bus.Month = 7'(m);
      bus.Year  = 7'(y);
      bus.send  = 1'b1;
      for (int s = 0; s < REPORT_CYCLES + 20; s++) begin
         @(negedge clk);
         tx_s.push_back(bus.tx);
         if (bus.busy === 1'b1) busy_n++;
         if (bus.done === 1'b1) begin
            done_n++;
            done_idx = s;
         end
         if (s == 0) begin
            check({tag, "_start_tx"}, 32'(bus.tx), 32'd0);
            check({tag, "_start_busy"}, 32'(bus.busy), 32'd1);
         end
         if (s == 1) bus.send = 1'b0;
         if (s == change_at) begin
            bus.Day   = 7'd1;
            bus.Month = 7'd1;
            bus.Year  = 7'd0;
         end
         if (s == glitch_at) bus.send = 1'b1;
         if (s == glitch_at + 1) bus.send = 1'b0;
         if (bus.done === 1'b1) break;
      end
      bus.send = 1'b0;

      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(REPORT_CYCLES));
      check({tag, "_done_count"}, 32'(done_n), 32'd1);
      check({tag, "_done_time"}, 32'(done_idx), 32'(REPORT_CYCLES));
      for (int j = 0; j < NB; j++) begin
         for (int k = 0; k < 10; k++) begin
            idx = (j * 10 + k) * N + N / 2;
            if (k == 0)      fr_start = (idx < tx_s.size()) ? tx_s[idx] : 1'bx;
            else if (k == 9) fr_stop  = (idx < tx_s.size()) ? tx_s[idx] : 1'bx;
            else             b[k-1]   = (idx < tx_s.size()) ? tx_s[idx] : 1'bx;
         end
         check($sformatf("%s_byte%0d", tag, j), {22'd0, fr_start, fr_stop, b},
               {22'd0, 1'b0, 1'b1, exp_q[j]});
      end
   endtask

   initial begin
      int bad;
      int rd, rm, ry;

      bus.Day = 7'd1; bus.Month = 7'd1; bus.Year = 7'd0;
      bus.send = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tx", 32'(bus.tx), 32'd1);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);

      reset = 1'b0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
      end
      check("held_send_no_frame", 32'(bad), 32'd0);
      bus.send = 1'b0;
      repeat (2) @(negedge clk);

      run_report("basic", 3, 3, 24, -1, -1);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.tx !== 1'b1) bad++;
      end
      check("basic_idle_after", 32'(bad), 32'd0);

      run_report("snapshot_hold", 31, 12, 99, 0, -1);
      @(negedge clk);
      run_report("year_clamp", 3, 3, 120, -1, -1);
      @(negedge clk);

      run_report("ignore_busy_send", 5, 6, 7, -1, 50);
      run_report("back_to_back", 8, 9, 10, -1, -1);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
      end
      check("no_queued_report", 32'(bad), 32'd0);

      bus.Day = 7'd2; bus.Month = 7'd2; bus.Year = 7'd22;
      bus.send = 1'b1;
      for (int s = 0; s < 43 * N + 2; s++) begin
         @(negedge clk);
         if (s == 1) bus.send = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      check("abort_tx", 32'(bus.tx), 32'd1);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      reset = 1'b0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
      end
      check("abort_quiet", 32'(bad), 32'd0);
      run_report("fresh_after_abort", 17, 11, 5, -1, -1);
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         rd = $urandom_range(1, 31);
         rm = $urandom_range(1, 12);
         ry = $urandom_range(0, 127);
         run_report($sformatf("rand%0d", i), rd, rm, ry, -1, -1);
         repeat ($urandom_range(1, 5)) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
